fetch_queue: RTL and testbench

Instruction fetch queue between the PC/fetch stage and decode. The block takes the PC address presented to instruction memory and the memory's 1-cycle-latency read data, and tags each returned instruction with its PC. It buffers the tagged instructions in a DEPTH-entry FIFO and presents them to decode with a valid/ready handshake. It drives `PC_enable` back to the fetch stage, so the PC advances only when a queue slot is reserved, and it discards all queued and in-flight work on `flush`.

---
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: memory request/return, redirect, and head-of-queue outputs.
// The queue takes the slave view; the fetch stage, memory and decode take the master view.
interface fetch_queue_if #(
   parameter int N     = 64,
   parameter int DEPTH = 4
);
   logic [N-1:0]              imem_addr_F;
   logic [31:0]               imem_rdata;
   logic                      flush;
   logic                      ready_D;
   logic                      PC_enable;
   logic                      imem_en;
   logic                      valid_D;
   logic [31:0]               instr_D;
   logic [N-1:0]              PC_D;
   logic [$clog2(DEPTH):0]    count;

   modport master (
      output imem_addr_F, imem_rdata, flush, ready_D,
      input  PC_enable, imem_en, valid_D, instr_D, PC_D, count
   );

   modport slave (
      input  imem_addr_F, imem_rdata, flush, ready_D,
      output PC_enable, imem_en, valid_D, instr_D, PC_D, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Tags 1-cycle-latency imem returns with their PC and queues them for decode; address to valid_D is 2 cycles.
// Backpressure: PC_enable only while a slot is reservable (count + inflight < DEPTH); flush discards everything.
module fetch_queue #(
   parameter int N     = 64,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset,
   fetch_queue_if.slave  bus
);
   localparam int              AW      = $clog2(DEPTH);
   localparam int              CW      = AW + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]     NOP     = 32'h0000_0013;

   logic [31:0]   instr_mem [DEPTH];
   logic [N-1:0]  pc_mem    [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          inflight;
   logic [N-1:0]  inflight_pc;

   logic [CW-1:0] reserved;
   logic          pc_en;
   logic          issue;
   logic          push;
   logic          pop;
   logic          head_vld;

   // Reservation counts the outstanding request so a return always finds a free slot.
   assign reserved = cnt + CW'(inflight);
   assign pc_en    = bus.flush | (reserved < DEPTH_C);
   assign issue    = pc_en & ~bus.flush;
   assign push     = inflight & ~bus.flush;
   assign head_vld = (cnt != '0);
   assign pop      = head_vld & bus.ready_D & ~bus.flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         inflight <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= issue;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Payload registers carry no reset; pointers and count decide what is live.
   always_ff @(posedge clk) begin
      if (issue) inflight_pc <= bus.imem_addr_F;
      if (push) begin
         instr_mem[wr_ptr] <= bus.imem_rdata;
         pc_mem[wr_ptr]    <= inflight_pc;
      end
   end

   assign bus.PC_enable = pc_en;
   assign bus.imem_en   = issue;
   assign bus.valid_D   = head_vld;
   assign bus.instr_D   = head_vld ? instr_mem[rd_ptr] : NOP;
   assign bus.PC_D      = head_vld ? pc_mem[rd_ptr] : '0;
   assign bus.count     = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a fetch PC register and 1-cycle memory (rdata = addr + 0x100) around the queue.
module tb_fetch_queue;
   localparam int          N     = 64;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();
   fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [N-1:0] pc = '0;
   logic [N-1:0] target = '0;

   // One clock: fetch/memory environment advances from pre-edge values, returns at edge+1.
   task automatic tick();
      logic         pe_s, fl_s, rst_s;
      logic [N-1:0] a_s;
      #1;
      pe_s  = bus.PC_enable;
      fl_s  = bus.flush;
      rst_s = reset;
      a_s   = bus.imem_addr_F;
      @(posedge clk);
      #1;
      bus.imem_rdata = 32'(a_s + 64'h100);
      if (!rst_s || !reset) pc = '0;
      else if (fl_s)        pc = target;
      else if (pe_s)        pc = pc + 64'd4;
      bus.imem_addr_F = pc;
   endtask

   task automatic apply_reset();
      bus.flush = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
      n_cmp++; if (bus.valid_D !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.valid_D); end
      n_cmp++; if (bus.instr_D !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", bus.instr_D, NOP); end
      n_cmp++; if (bus.PC_D !== 64'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", bus.PC_D); end
      n_cmp++; if (bus.PC_enable !== 1'b1) begin n_bad++; $display("FAIL reset_pc_enable: got %b want 1", bus.PC_enable); end
   endtask

   task automatic test_stream();
      bus.ready_D = 1'b1;
      apply_reset();
      #1;
      n_cmp++; if (bus.imem_en !== 1'b1) begin n_bad++; $display("FAIL stream_imem_en: got %b want 1", bus.imem_en); end
      tick();
      n_cmp++; if (bus.valid_D !== 1'b0) begin n_bad++; $display("FAIL stream_valid_c1: got %b want 0", bus.valid_D); end
      tick();
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'(4 * k) || bus.instr_D !== 32'(4 * k + 'h100)
             || bus.PC_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL stream_head[%0d]: got v=%b pc=%h i=%h en=%b want v=1 pc=%h i=%h en=1",
                     k, bus.valid_D, bus.PC_D, bus.instr_D, bus.PC_enable, 4 * k, 4 * k + 'h100);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      bus.ready_D = 1'b0;
      apply_reset();
      repeat (4) tick();
      n_cmp++; if (bus.count !== 3'd3 || bus.PC_enable !== 1'b0) begin n_bad++; $display("FAIL bp_c4: got cnt=%0d en=%b want cnt=3 en=0", bus.count, bus.PC_enable); end
      tick();
      n_cmp++; if (bus.count !== 3'd4 || bus.PC_enable !== 1'b0) begin n_bad++; $display("FAIL bp_full: got cnt=%0d en=%b want cnt=4 en=0", bus.count, bus.PC_enable); end
      n_cmp++; if (bus.PC_D !== 64'h0 || bus.instr_D !== 32'h100) begin n_bad++; $display("FAIL bp_head0: got pc=%h i=%h want 0/100", bus.PC_D, bus.instr_D); end
      tick();
      n_cmp++; if (bus.count !== 3'd4 || bus.PC_D !== 64'h0) begin n_bad++; $display("FAIL bp_hold: got cnt=%0d pc=%h want 4/0", bus.count, bus.PC_D); end
      bus.ready_D = 1'b1;
      tick();
      bus.ready_D = 1'b0;
      n_cmp++; if (bus.count !== 3'd3 || bus.PC_enable !== 1'b1 || bus.PC_D !== 64'h4) begin n_bad++; $display("FAIL bp_pop1: got cnt=%0d en=%b pc=%h want 3/1/4", bus.count, bus.PC_enable, bus.PC_D); end
      tick();
      tick();
      n_cmp++; if (bus.count !== 3'd4) begin n_bad++; $display("FAIL bp_refill: got cnt=%0d want 4", bus.count); end
      bus.ready_D = 1'b1;
      for (int k = 0; k < 6; k++) begin
         n_cmp++;
         if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'(4 + 4 * k) || bus.instr_D !== 32'(4 + 4 * k + 'h100)) begin
            n_bad++;
            $display("FAIL bp_wrap[%0d]: got v=%b pc=%h i=%h want pc=%h", k, bus.valid_D, bus.PC_D, bus.instr_D, 4 + 4 * k);
         end
         tick();
      end
   endtask

   task automatic test_push_pop_at_three();
      bus.ready_D = 1'b0;
      apply_reset();
      repeat (4) tick();
      bus.ready_D = 1'b1;
      #1;
      n_cmp++; if (bus.PC_enable !== 1'b0) begin n_bad++; $display("FAIL pp_pc_enable: got %b want 0", bus.PC_enable); end
      tick();
      n_cmp++; if (bus.count !== 3'd3 || bus.PC_D !== 64'h4 || bus.instr_D !== 32'h104) begin n_bad++; $display("FAIL pp_same: got cnt=%0d pc=%h i=%h want 3/4/104", bus.count, bus.PC_D, bus.instr_D); end
      tick();
      n_cmp++; if (bus.count !== 3'd2 || bus.PC_D !== 64'h8) begin n_bad++; $display("FAIL pp_next: got cnt=%0d pc=%h want 2/8", bus.count, bus.PC_D); end
   endtask

   task automatic test_flush_inflight();
      int waited;
      bus.ready_D = 1'b0;
      apply_reset();
      repeat (3) tick();
      n_cmp++; if (bus.count !== 3'd2) begin n_bad++; $display("FAIL fl_pre_count: got %0d want 2", bus.count); end
      target = 64'h200;
      bus.flush = 1'b1;
      #1;
      n_cmp++; if (bus.PC_enable !== 1'b1 || bus.imem_en !== 1'b0) begin n_bad++; $display("FAIL fl_strobes: got en=%b imem_en=%b want 1/0", bus.PC_enable, bus.imem_en); end
      tick();
      bus.flush = 1'b0;
      n_cmp++; if (bus.count !== 3'd0 || bus.valid_D !== 1'b0 || bus.instr_D !== NOP) begin n_bad++; $display("FAIL fl_empty: got cnt=%0d v=%b i=%h want 0/0/13", bus.count, bus.valid_D, bus.instr_D); end
      waited = 0;
      while (!bus.valid_D && waited < 6) begin tick(); waited++; end
      n_cmp++; if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'h200 || bus.instr_D !== 32'h300 || bus.count !== 3'd1) begin n_bad++; $display("FAIL fl_target: got v=%b pc=%h i=%h cnt=%0d want 1/200/300/1", bus.valid_D, bus.PC_D, bus.instr_D, bus.count); end
      tick();
      n_cmp++; if (bus.PC_D !== 64'h200 || bus.instr_D !== 32'h300) begin n_bad++; $display("FAIL fl_stable: got pc=%h i=%h want 200/300", bus.PC_D, bus.instr_D); end
   endtask

   task automatic test_flush_with_pop();
      int waited;
      bus.ready_D = 1'b1;
      apply_reset();
      repeat (3) tick();
      n_cmp++; if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'h4) begin n_bad++; $display("FAIL fp_pre: got v=%b pc=%h want 1/4", bus.valid_D, bus.PC_D); end
      target = 64'h400;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      n_cmp++; if (bus.count !== 3'd0 || bus.valid_D !== 1'b0) begin n_bad++; $display("FAIL fp_empty: got cnt=%0d v=%b want 0/0", bus.count, bus.valid_D); end
      waited = 0;
      while (!bus.valid_D && waited < 6) begin tick(); waited++; end
      n_cmp++; if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'h400 || bus.instr_D !== 32'h500) begin n_bad++; $display("FAIL fp_target: got v=%b pc=%h i=%h want 1/400/500", bus.valid_D, bus.PC_D, bus.instr_D); end
      tick();
      n_cmp++; if (bus.PC_D !== 64'h404 || bus.instr_D !== 32'h504) begin n_bad++; $display("FAIL fp_next: got pc=%h i=%h want 404/504", bus.PC_D, bus.instr_D); end
   endtask

   task automatic test_async_reset();
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.valid_D !== 1'b0 || bus.count !== 3'd0 || bus.PC_enable !== 1'b1) begin n_bad++; $display("FAIL ar_immediate: got v=%b cnt=%0d en=%b want 0/0/1", bus.valid_D, bus.count, bus.PC_enable); end
      tick();
      tick();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (bus.valid_D !== 1'b1 || bus.PC_D !== 64'h0 || bus.instr_D !== 32'h100) begin n_bad++; $display("FAIL ar_restart: got v=%b pc=%h i=%h want 1/0/100", bus.valid_D, bus.PC_D, bus.instr_D); end
      tick();
      n_cmp++; if (bus.PC_D !== 64'h4 || bus.instr_D !== 32'h104) begin n_bad++; $display("FAIL ar_second: got pc=%h i=%h want 4/104", bus.PC_D, bus.instr_D); end
   endtask

   initial begin
      bus.imem_addr_F = '0;
      bus.imem_rdata  = '0;
      bus.flush       = 1'b0;
      bus.ready_D     = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_push_pop_at_three();
      test_flush_inflight();
      test_flush_with_pop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
